// File: rtl/regs_bank_pkg.sv
// +---------------------------------------------------------------------+
// | regs_bank_pkg : shared defaults and helpers for the register bank   |
// | Revision 1.0                                                        |
// +---------------------------------------------------------------------+
`default_nettype none

package regs_bank_pkg;

  localparam int c_data_w   = 16;
  localparam int c_addr_w   = 3;
  localparam int c_zero_reg = 1;

  // True when the index is the hardwired-zero register.
  function automatic logic is_zero_index(input int zero_reg, input int idx);
    return (zero_reg != 0) && (idx == 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/regs_bank_sb_if.sv
// +---------------------------------------------------------------------+
// | regs_bank_sb_if : write, read and reservation ports of the bank     |
// | Revision 1.0                                                        |
// +---------------------------------------------------------------------+
`default_nettype none

interface regs_bank_sb_if
  import regs_bank_pkg::*;
#(
  parameter int DATA_W = c_data_w,
  parameter int ADDR_W = c_addr_w
);

  logic              regWrite;
  logic [ADDR_W-1:0] writeAddr;
  logic [DATA_W-1:0] dataToWrite;
  logic              readEn;
  logic [ADDR_W-1:0] reg1;
  logic [ADDR_W-1:0] reg2;
  logic              reserveEn;
  logic [ADDR_W-1:0] reserveAddr;
  logic [DATA_W-1:0] data1;
  logic [DATA_W-1:0] data2;
  logic              pending1;
  logic              pending2;

  modport master (
    output regWrite, writeAddr, dataToWrite, readEn, reg1, reg2,
           reserveEn, reserveAddr,
    input  data1, data2, pending1, pending2
  );

  modport slave (
    input  regWrite, writeAddr, dataToWrite, readEn, reg1, reg2,
           reserveEn, reserveAddr,
    output data1, data2, pending1, pending2
  );

endinterface

`default_nettype wire

// File: rtl/regs_bank_sb_scoreboard.sv
// +---------------------------------------------------------------------+
// | regs_scoreboard : one pending bit per register, set wins over clear |
// | Revision 1.0                                                        |
// +---------------------------------------------------------------------+
`default_nettype none

module regs_scoreboard #(
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 1
) (
  input  wire logic              clock,
  input  wire logic              resetN,
  input  wire logic              set,
  input  wire logic [ADDR_W-1:0] setAddr,
  input  wire logic              clr,
  input  wire logic [ADDR_W-1:0] clrAddr,
  input  wire logic [ADDR_W-1:0] qAddr1,
  input  wire logic [ADDR_W-1:0] qAddr2,
  output logic                   qPending1,
  output logic                   qPending2
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] r_pending;
  logic [DEPTH-1:0] w_pending_next;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_bit
      if ((ZERO_REG != 0) && (gi == 0)) begin : g_zero
        assign w_pending_next[gi] = 1'b0;
      end else begin : g_live
        assign w_pending_next[gi] =
            (set && (setAddr == ADDR_W'(gi))) ? 1'b1 :
            (clr && (clrAddr == ADDR_W'(gi))) ? 1'b0 : r_pending[gi];
      end
    end
  endgenerate

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) r_pending <= '0;
    else         r_pending <= w_pending_next;
  end

  // Queries see the post-edge value so a read captures this cycle's updates.
  assign qPending1 = w_pending_next[qAddr1];
  assign qPending2 = w_pending_next[qAddr2];

endmodule

`default_nettype wire

// File: rtl/regs_bank_sb.sv
// +---------------------------------------------------------------------+
// | regs_bank_sb : register bank, write-first bypass, pending scoreboard|
// | Revision 1.0                                                        |
// +---------------------------------------------------------------------+
`default_nettype none

module regs_bank_sb
  import regs_bank_pkg::*;
#(
  parameter int DATA_W   = c_data_w,
  parameter int ADDR_W   = c_addr_w,
  parameter int ZERO_REG = c_zero_reg
) (
  input  wire logic     clock,
  input  wire logic     resetN,
  regs_bank_sb_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DATA_W-1:0] r_data1, r_data2;
  logic              r_pending1, r_pending2;
  logic [DATA_W-1:0] w_rd1, w_rd2;
  logic              w_wr_en;
  logic              w_pend1, w_pend2;

  assign w_wr_en = bus.regWrite && !is_zero_index(ZERO_REG, int'(bus.writeAddr));

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[bus.writeAddr] <= bus.dataToWrite;
    end
  end

  // Write-first: a same-cycle write to the read index forwards the new data.
  always_comb begin
    w_rd1 = r_regs[bus.reg1];
    if (is_zero_index(ZERO_REG, int'(bus.reg1)))         w_rd1 = '0;
    else if (w_wr_en && (bus.writeAddr == bus.reg1))     w_rd1 = bus.dataToWrite;
  end

  always_comb begin
    w_rd2 = r_regs[bus.reg2];
    if (is_zero_index(ZERO_REG, int'(bus.reg2)))         w_rd2 = '0;
    else if (w_wr_en && (bus.writeAddr == bus.reg2))     w_rd2 = bus.dataToWrite;
  end

  regs_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clock     (clock),
    .resetN    (resetN),
    .set       (bus.reserveEn),
    .setAddr   (bus.reserveAddr),
    .clr       (bus.regWrite),
    .clrAddr   (bus.writeAddr),
    .qAddr1    (bus.reg1),
    .qAddr2    (bus.reg2),
    .qPending1 (w_pend1),
    .qPending2 (w_pend2)
  );

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_data1    <= '0;
      r_data2    <= '0;
      r_pending1 <= 1'b0;
      r_pending2 <= 1'b0;
    end else if (bus.readEn) begin
      r_data1    <= w_rd1;
      r_data2    <= w_rd2;
      r_pending1 <= w_pend1;
      r_pending2 <= w_pend2;
    end
  end

  assign bus.data1    = r_data1;
  assign bus.data2    = r_data2;
  assign bus.pending1 = r_pending1;
  assign bus.pending2 = r_pending2;

endmodule

`default_nettype wire

// File: doc/regs_bank_sb.md
REGS_BANK_SB -- requirements
Module: regs_bank_sb

Interface
REQ-001 Parameter DATA_W, default 16, register data width in bits.
REQ-002 Parameter ADDR_W, default 3, register address width; DEPTH = 2**ADDR_W registers.
REQ-003 Parameter ZERO_REG, default 1; 1 = register 0 reads as zero and ignores writes and reservations.
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 resetN  input  1  asynchronous, active-low reset.
REQ-006 regWrite  input  1  write enable for the write port.
REQ-007 writeAddr  input  ADDR_W  write-port register index.
REQ-008 dataToWrite  input  DATA_W  write-port data.
REQ-009 readEn  input  1  read-port capture enable (both ports).
REQ-010 reg1, reg2  input  ADDR_W each  read-port register indices.
REQ-011 reserveEn  input  1  mark a register as awaiting write-back.
REQ-012 reserveAddr  input  ADDR_W  register index to reserve.
REQ-013 data1, data2  output  DATA_W each  registered read data.
REQ-014 pending1, pending2  output  1 each  registered pending status of the register read.

Function
REQ-015 Write: on a rising edge with regWrite=1, registers[writeAddr] SHALL take dataToWrite; writes to index 0 SHALL be dropped when ZERO_REG=1.
REQ-016 Read latency: on a rising edge with readEn=1, data1/data2 SHALL capture registers[reg1]/registers[reg2]; one-cycle latency; outputs SHALL hold when readEn=0.
REQ-017 Bypass: if regWrite=1 and writeAddr equals reg1 (or reg2) in the same cycle, the captured data SHALL be dataToWrite, not the old content (write-first), except index 0 with ZERO_REG=1, which SHALL read 0.
REQ-018 Both read ports SHALL resolve the same address independently and identically.
REQ-019 Scoreboard: one pending bit per register; reserveEn=1 SHALL set pending[reserveAddr] at the edge; regWrite=1 SHALL clear pending[writeAddr] at the edge.
REQ-020 Simultaneous reserve and write to the same index SHALL leave the pending bit set (new reservation wins); the data is still written.
REQ-021 pending1/pending2 SHALL capture, under readEn, the pending bit value after that edge's clear/set updates for reg1/reg2.
REQ-022 With ZERO_REG=1, pending[0] SHALL remain 0 permanently.
REQ-023 Out-of-range indices cannot occur (DEPTH = 2**ADDR_W); no error output is required.

Reset
REQ-024 resetN=0 SHALL immediately clear all registers, all pending bits, data1, data2, pending1 and pending2 to 0, regardless of clock.
REQ-025 Writes, reservations and reads presented while resetN=0 SHALL be ignored; the first update occurs on the first rising edge after resetN deasserts.

Structure
REQ-026 A shared package regs_bank_pkg SHALL hold default DATA_W, ADDR_W and ZERO_REG constants used by the processor top.
REQ-027 The pending-bit scoreboard SHALL be a sub-module regs_scoreboard (ports: clock, resetN, set, setAddr, clr, clrAddr, query indices, pending outputs).
REQ-028 Storage SHALL be a single array of DEPTH x DATA_W flops; no negative-edge logic.

Verification
REQ-029 Reset then readEn=1, reg1=3, reg2=5 -> next cycle data1=0, data2=0, pending1=0, pending2=0.
REQ-030 Write 16'hBEEF to reg 4, next cycle read reg1=4 -> data1=16'hBEEF; same-cycle write 16'h1234 to reg 6 with reg2=6 -> data2=16'h1234 (bypass).
REQ-031 ZERO_REG=1: write 16'hFFFF to reg 0 and reserve reg 0, then read reg1=0 -> data1=0, pending1=0.
REQ-032 Reserve reg 2, read reg1=2 -> pending1=1; write reg 2 with 16'h0042 while reading reg1=2 -> data1=16'h0042, pending1=0.
REQ-033 Same cycle reserveEn=1 and regWrite=1 on reg 7 with 16'h0007, then read reg2=7 -> data2=16'h0007, pending2=1.
REQ-034 Assert resetN=0 mid-clock after reg 1 holds 16'hAAAA and is pending -> data1/pending1 drop to 0 before the next edge; read reg1=1 after release -> 0/0.
